id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register of the five-stage MIPS datapath, combined with load-use hazard detection. It latches decoded operands and control from ID and presents them as the `ex_*` signals. Those signals drive the EX-stage forwarding unit (`ex_Ra`, `ex_Rb`) and the ALU. The block also inserts a bubble on a load-use hazard or a pipeline flush, issues hold requests to the PC and the IF/ID register, and keeps stall and flush event counters.

## Interface
Parameters:
- `DATA_W`, 32, datapath width.
- `REG_AW`, 5, register address width.
- `ALUCTR_W`, 4, ALU control width.
- `CNT_W`, 32, event counter width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  the ID stage holds a real instruction.
- `id_Ra`, `id_Rb`, `id_Rw`  in  REG_AW each  source and destination register numbers.
- `id_RbUsed`  in  1  the instruction reads Rb (R-type, store, branch).
- `id_RegWr`, `id_MemWr`, `id_MemtoReg`, `id_ALUSrc`, `id_Branch`  in  1 each  decoded control signals.
- `id_ALUctr`  in  ALUCTR_W  ALU operation.
- `id_busA`, `id_busB`, `id_imm32`, `id_pc`  in  DATA_W each  operands, extended immediate, PC+4.
- `flush`  in  1  branch taken or jump resolved downstream; squash the ID instruction.
- `ex_*`  out  registered copies of every `id_*` field above, plus `ex_valid`.
- `pc_hold`, `ifid_hold`  out  1 each  freeze the PC and the IF/ID register this cycle.
- `stall_cnt`, `flush_cnt`  out  CNT_W each  event counters.

## Operation
- Hazard condition, combinational: `hazard = ex_valid & ex_MemtoReg & ex_RegWr & (ex_Rw != 0) & id_valid & ((ex_Rw == id_Ra) | (id_RbUsed & ex_Rw == id_Rb))`.
- `stall = hazard & ~flush`. A flush squashes the dependent instruction, so it takes priority over a stall.
- `pc_hold = ifid_hold = stall`.
- Next-state priority at each edge:
  1. `flush` → load a bubble.
  2. `stall` → load a bubble.
  3. Otherwise → load all `id_*` fields; `ex_valid <= id_valid`.
- Bubble definition:
  - `ex_valid`, `ex_RegWr`, `ex_MemWr`, `ex_MemtoReg`, `ex_Branch`, `ex_ALUSrc` = 0.
  - `ex_Ra`, `ex_Rb`, `ex_Rw` = 0, so the forwarding unit selects no forward.
  - `ex_ALUctr` = 0.
  - Data fields (`busA`, `busB`, `imm32`, `pc`) are don't-care but are driven to 0.
- Forwarding for a stalled instruction is resolved by the forwarding unit once the load reaches MEM/WB. The block does not compare MEM/WB destinations.
- Counters:
  - `stall_cnt` increments on every edge with `stall = 1`.
  - `flush_cnt` increments on every edge with `flush = 1`.
  - Both wrap modulo 2^CNT_W with no saturation.

## Timing
- Latency: one cycle from `id_*` to `ex_*`.
- `pc_hold`, `ifid_hold`, `hazard` and `stall` are combinational, valid within the same cycle.
- A single load-use dependence produces exactly one stall cycle. In the next cycle the load has left EX, so `hazard` is 0.
- `flush` and `hazard` asserted together: a bubble is loaded, `stall = 0`, `flush_cnt` increments and `stall_cnt` does not.
- `id_valid = 0`: no hazard is possible, and `ex_valid` loads 0.
- `rst` asserted, including mid-stall: every `ex_*` register and both counters clear immediately (asynchronously). `pc_hold` and `ifid_hold` are then 0, because `ex_valid = 0`.
- The first edge after `rst` is released loads normally.

## Structure
- A shared pipeline package holds:
  - the width constants `DATA_W`, `REG_AW`, `ALUCTR_W`;
  - the `ALUctr` encodings;
  - a packed struct type `idex_ctrl_t` containing `RegWr`, `MemWr`, `MemtoReg`, `ALUSrc`, `Branch`, `ALUctr`;
  - a constant `IDEX_BUBBLE`, the bubble value of that struct.
- One sub-module, `load_use_detect`, holds the pure combinational `hazard` equation, so it can be reused and tested in isolation.
- The registers and counters live in `id_ex_stage`.

## Test plan
- Plain pass-through: `id_Ra=1`, `id_Rb=2`, `id_Rw=3`, `id_RegWr=1`, `id_busA=0x11` → after one edge `ex_Ra=1`, `ex_Rw=3`, `ex_busA=0x11`, `ex_valid=1`, holds 0.
- Load-use on Ra: EX holds `lw $8` (`MemtoReg=1`, `RegWr=1`, `Rw=8`); ID holds `add` with `Ra=8` → `pc_hold=ifid_hold=1` for one cycle; next `ex_*` is a bubble (`ex_Rw=0`, `ex_RegWr=0`); the cycle after that, `add` enters EX; `stall_cnt=1`.
- Rb ignored when unused: EX `lw $8`; ID `addi` with `Rb=8`, `id_RbUsed=0` → no stall; same case with `id_RbUsed=1` → stall.
- `$0` destination: EX `lw $0`, ID `Ra=0` → no stall.
- Flush over hazard: hazard present and `flush=1` → bubble loaded, holds 0, `flush_cnt=1`, `stall_cnt=0`.
- Reset mid-stall: assert `rst` while `stall=1` → all `ex_*`, `stall_cnt` and `flush_cnt` read 0 before the next edge, holds 0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline package for the ID/EX boundary: datapath widths, ALU op
// encodings, and the packed control bundle carried from ID into EX.
package id_ex_stage_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int ALUCTR_W = 4;

  localparam logic [ALUCTR_W-1:0] ALU_ADDU = 4'd0;
  localparam logic [ALUCTR_W-1:0] ALU_ADD  = 4'd1;
  localparam logic [ALUCTR_W-1:0] ALU_SUBU = 4'd2;
  localparam logic [ALUCTR_W-1:0] ALU_SUB  = 4'd3;
  localparam logic [ALUCTR_W-1:0] ALU_AND  = 4'd4;
  localparam logic [ALUCTR_W-1:0] ALU_OR   = 4'd5;
  localparam logic [ALUCTR_W-1:0] ALU_XOR  = 4'd6;
  localparam logic [ALUCTR_W-1:0] ALU_NOR  = 4'd7;
  localparam logic [ALUCTR_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALUCTR_W-1:0] ALU_SLTU = 4'd9;
  localparam logic [ALUCTR_W-1:0] ALU_SLL  = 4'd10;
  localparam logic [ALUCTR_W-1:0] ALU_SRL  = 4'd11;
  localparam logic [ALUCTR_W-1:0] ALU_SRA  = 4'd12;
  localparam logic [ALUCTR_W-1:0] ALU_LUI  = 4'd13;

  typedef struct packed {
    logic                RegWr;
    logic                MemWr;
    logic                MemtoReg;
    logic                ALUSrc;
    logic                Branch;
    logic [ALUCTR_W-1:0] ALUctr;
  } idex_ctrl_t;

  // A bubble writes nothing, touches no memory and never branches.
  localparam idex_ctrl_t IDEX_BUBBLE = '{
    RegWr:    1'b0,
    MemWr:    1'b0,
    MemtoReg: 1'b0,
    ALUSrc:   1'b0,
    Branch:   1'b0,
    ALUctr:   ALU_ADDU
  };

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: a load in EX whose nonzero destination is read by
// the valid instruction in ID. Purely combinational, zero latency.
module load_use_detect #(
  parameter int REG_AW = id_ex_stage_pkg::REG_AW
) (
  input  logic              ex_valid,
  input  logic              ex_MemtoReg,
  input  logic              ex_RegWr,
  input  logic [REG_AW-1:0] ex_Rw,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_Ra,
  input  logic [REG_AW-1:0] id_Rb,
  input  logic              id_RbUsed,
  output logic              hazard
);

  logic ex_is_load;
  logic id_reads_rw;

  assign ex_is_load  = ex_valid & ex_MemtoReg & ex_RegWr & (ex_Rw != '0);
  assign id_reads_rw = (ex_Rw == id_Ra) | (id_RbUsed & (ex_Rw == id_Rb));
  assign hazard      = ex_is_load & id_valid & id_reads_rw;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, PC/IF-ID hold
// requests and stall/flush event counters. One cycle ID->EX; holds are same-cycle.
module id_ex_stage #(
  parameter int DATA_W   = id_ex_stage_pkg::DATA_W,
  parameter int REG_AW   = id_ex_stage_pkg::REG_AW,
  parameter int ALUCTR_W = id_ex_stage_pkg::ALUCTR_W,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_Ra,
  input  logic [REG_AW-1:0]   id_Rb,
  input  logic [REG_AW-1:0]   id_Rw,
  input  logic                id_RbUsed,
  input  logic                id_RegWr,
  input  logic                id_MemWr,
  input  logic                id_MemtoReg,
  input  logic                id_ALUSrc,
  input  logic                id_Branch,
  input  logic [ALUCTR_W-1:0] id_ALUctr,
  input  logic [DATA_W-1:0]   id_busA,
  input  logic [DATA_W-1:0]   id_busB,
  input  logic [DATA_W-1:0]   id_imm32,
  input  logic [DATA_W-1:0]   id_pc,
  input  logic                flush,
  output logic                ex_valid,
  output logic [REG_AW-1:0]   ex_Ra,
  output logic [REG_AW-1:0]   ex_Rb,
  output logic [REG_AW-1:0]   ex_Rw,
  output logic                ex_RbUsed,
  output logic                ex_RegWr,
  output logic                ex_MemWr,
  output logic                ex_MemtoReg,
  output logic                ex_ALUSrc,
  output logic                ex_Branch,
  output logic [ALUCTR_W-1:0] ex_ALUctr,
  output logic [DATA_W-1:0]   ex_busA,
  output logic [DATA_W-1:0]   ex_busB,
  output logic [DATA_W-1:0]   ex_imm32,
  output logic [DATA_W-1:0]   ex_pc,
  output logic                pc_hold,
  output logic                ifid_hold,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  import id_ex_stage_pkg::*;

  logic       hazard;
  logic       stall;
  logic       bubble;
  idex_ctrl_t ctrl_id;
  idex_ctrl_t ctrl_q;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .ex_valid    (ex_valid),
    .ex_MemtoReg (ex_MemtoReg),
    .ex_RegWr    (ex_RegWr),
    .ex_Rw       (ex_Rw),
    .id_valid    (id_valid),
    .id_Ra       (id_Ra),
    .id_Rb       (id_Rb),
    .id_RbUsed   (id_RbUsed),
    .hazard      (hazard)
  );

  // Flush squashes the dependent instruction anyway, so it wins over a stall.
  assign stall     = hazard & ~flush;
  assign bubble    = flush | stall;
  assign pc_hold   = stall;
  assign ifid_hold = stall;

  always_comb begin
    ctrl_id          = IDEX_BUBBLE;
    ctrl_id.RegWr    = id_RegWr;
    ctrl_id.MemWr    = id_MemWr;
    ctrl_id.MemtoReg = id_MemtoReg;
    ctrl_id.ALUSrc   = id_ALUSrc;
    ctrl_id.Branch   = id_Branch;
    ctrl_id.ALUctr   = id_ALUctr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ctrl_q    <= IDEX_BUBBLE;
      ex_Ra     <= '0;
      ex_Rb     <= '0;
      ex_Rw     <= '0;
      ex_RbUsed <= 1'b0;
      ex_busA   <= '0;
      ex_busB   <= '0;
      ex_imm32  <= '0;
      ex_pc     <= '0;
    end else if (bubble) begin
      // Zero register numbers keep the forwarding unit from matching a bubble.
      ex_valid  <= 1'b0;
      ctrl_q    <= IDEX_BUBBLE;
      ex_Ra     <= '0;
      ex_Rb     <= '0;
      ex_Rw     <= '0;
      ex_RbUsed <= 1'b0;
      ex_busA   <= '0;
      ex_busB   <= '0;
      ex_imm32  <= '0;
      ex_pc     <= '0;
    end else begin
      ex_valid  <= id_valid;
      ctrl_q    <= ctrl_id;
      ex_Ra     <= id_Ra;
      ex_Rb     <= id_Rb;
      ex_Rw     <= id_Rw;
      ex_RbUsed <= id_RbUsed;
      ex_busA   <= id_busA;
      ex_busB   <= id_busB;
      ex_imm32  <= id_imm32;
      ex_pc     <= id_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign ex_RegWr    = ctrl_q.RegWr;
  assign ex_MemWr    = ctrl_q.MemWr;
  assign ex_MemtoReg = ctrl_q.MemtoReg;
  assign ex_ALUSrc   = ctrl_q.ALUSrc;
  assign ex_Branch   = ctrl_q.Branch;
  assign ex_ALUctr   = ctrl_q.ALUctr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios then random traffic,
// expected EX contents, holds and counters come from a behavioural model.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int NW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          id_valid, id_RbUsed, id_RegWr, id_MemWr, id_MemtoReg, id_ALUSrc, id_Branch, flush;
  logic [AW-1:0] id_Ra, id_Rb, id_Rw;
  logic [CW-1:0] id_ALUctr;
  logic [DW-1:0] id_busA, id_busB, id_imm32, id_pc;
  logic          ex_valid, ex_RbUsed, ex_RegWr, ex_MemWr, ex_MemtoReg, ex_ALUSrc, ex_Branch;
  logic [AW-1:0] ex_Ra, ex_Rb, ex_Rw;
  logic [CW-1:0] ex_ALUctr;
  logic [DW-1:0] ex_busA, ex_busB, ex_imm32, ex_pc;
  logic          pc_hold, ifid_hold;
  logic [NW-1:0] stall_cnt, flush_cnt;

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .ALUCTR_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_Ra(id_Ra), .id_Rb(id_Rb), .id_Rw(id_Rw), .id_RbUsed(id_RbUsed),
    .id_RegWr(id_RegWr), .id_MemWr(id_MemWr), .id_MemtoReg(id_MemtoReg),
    .id_ALUSrc(id_ALUSrc), .id_Branch(id_Branch), .id_ALUctr(id_ALUctr),
    .id_busA(id_busA), .id_busB(id_busB), .id_imm32(id_imm32), .id_pc(id_pc),
    .flush(flush), .ex_valid(ex_valid),
    .ex_Ra(ex_Ra), .ex_Rb(ex_Rb), .ex_Rw(ex_Rw), .ex_RbUsed(ex_RbUsed),
    .ex_RegWr(ex_RegWr), .ex_MemWr(ex_MemWr), .ex_MemtoReg(ex_MemtoReg),
    .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch), .ex_ALUctr(ex_ALUctr),
    .ex_busA(ex_busA), .ex_busB(ex_busB), .ex_imm32(ex_imm32), .ex_pc(ex_pc),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // What the EX stage should be showing, plus counters and the hold request.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] Ra, Rb, Rw;
    logic          RbUsed, RegWr, MemWr, MemtoReg, ALUSrc, Branch;
    logic [CW-1:0] ALUctr;
    logic [DW-1:0] busA, busB, imm32, pc;
    logic [NW-1:0] scnt, fcnt;
    logic          hold;
  } exp_t;

  exp_t sbq[$];
  exp_t m;
  exp_t e;
  logic exp_hold;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples once per negedge, and right after an asynchronous reset.
  initial begin
    forever begin
      @(negedge clk or posedge rst);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("ex_valid",    64'(ex_valid),    64'(e.valid));
        chk("ex_Ra",       64'(ex_Ra),       64'(e.Ra));
        chk("ex_Rb",       64'(ex_Rb),       64'(e.Rb));
        chk("ex_Rw",       64'(ex_Rw),       64'(e.Rw));
        chk("ex_RbUsed",   64'(ex_RbUsed),   64'(e.RbUsed));
        chk("ex_RegWr",    64'(ex_RegWr),    64'(e.RegWr));
        chk("ex_MemWr",    64'(ex_MemWr),    64'(e.MemWr));
        chk("ex_MemtoReg", 64'(ex_MemtoReg), 64'(e.MemtoReg));
        chk("ex_ALUSrc",   64'(ex_ALUSrc),   64'(e.ALUSrc));
        chk("ex_Branch",   64'(ex_Branch),   64'(e.Branch));
        chk("ex_ALUctr",   64'(ex_ALUctr),   64'(e.ALUctr));
        chk("ex_busA",     64'(ex_busA),     64'(e.busA));
        chk("ex_busB",     64'(ex_busB),     64'(e.busB));
        chk("ex_imm32",    64'(ex_imm32),    64'(e.imm32));
        chk("ex_pc",       64'(ex_pc),       64'(e.pc));
        chk("pc_hold",     64'(pc_hold),     64'(e.hold));
        chk("ifid_hold",   64'(ifid_hold),   64'(e.hold));
        chk("stall_cnt",   64'(stall_cnt),   64'(e.scnt));
        chk("flush_cnt",   64'(flush_cnt),   64'(e.fcnt));
      end
    end
  end

  // Reference rule: a load sitting in EX that writes a real register which the
  // instruction in ID reads must make ID wait one cycle, unless ID is flushed.
  function automatic logic must_wait(input exp_t cur);
    logic ex_loads, id_reads;
    ex_loads = cur.valid && cur.MemtoReg && cur.RegWr && (cur.Rw != 0);
    id_reads = (id_Ra == cur.Rw) || (id_RbUsed && (id_Rb == cur.Rw));
    return ex_loads && id_valid && id_reads && !flush;
  endfunction

  task automatic push_expect();
    exp_t x;
    exp_hold = must_wait(m);
    x = m;
    x.hold = exp_hold;
    sbq.push_back(x);
  endtask

  task automatic advance();
    exp_t nx;
    nx = '0;
    if (!rst) begin
      nx.scnt = m.scnt + (exp_hold ? 1 : 0);
      nx.fcnt = m.fcnt + (flush ? 1 : 0);
      if (!(flush || exp_hold)) begin
        nx.valid = id_valid;   nx.Ra = id_Ra;       nx.Rb = id_Rb;   nx.Rw = id_Rw;
        nx.RbUsed = id_RbUsed; nx.RegWr = id_RegWr; nx.MemWr = id_MemWr;
        nx.MemtoReg = id_MemtoReg; nx.ALUSrc = id_ALUSrc; nx.Branch = id_Branch;
        nx.ALUctr = id_ALUctr; nx.busA = id_busA;   nx.busB = id_busB;
        nx.imm32 = id_imm32;   nx.pc = id_pc;
      end
    end
    m = nx;
  endtask

  task automatic step();
    push_expect();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_Ra = 0; id_Rb = 0; id_Rw = 0; id_RbUsed = 0;
    id_RegWr = 0; id_MemWr = 0; id_MemtoReg = 0; id_ALUSrc = 0; id_Branch = 0;
    id_ALUctr = 0; id_busA = 0; id_busB = 0; id_imm32 = 0; id_pc = 0; flush = 0;
  endtask

  task automatic load_word(input logic [AW-1:0] rw);
    idle();
    id_valid = 1; id_Ra = 5'd1; id_Rw = rw; id_RegWr = 1; id_MemtoReg = 1; id_ALUSrc = 1;
    id_imm32 = 32'h10; id_pc = 32'h100;
  endtask

  task automatic alu_op(input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic rbused);
    idle();
    id_valid = 1; id_Ra = ra; id_Rb = rb; id_RbUsed = rbused; id_Rw = 5'd10;
    id_RegWr = 1; id_ALUSrc = !rbused; id_ALUctr = 4'd1;
    id_busA = 32'hA0A0; id_busB = 32'hB0B0; id_imm32 = 32'h4; id_pc = 32'h104;
  endtask

  task automatic random_in();
    id_valid = ($urandom_range(0, 7) != 0);
    id_Ra = AW'($urandom_range(0, 3)); id_Rb = AW'($urandom_range(0, 3));
    id_Rw = AW'($urandom_range(0, 3)); id_RbUsed = 1'($urandom);
    id_RegWr = 1'($urandom); id_MemWr = 1'($urandom); id_MemtoReg = 1'($urandom);
    id_ALUSrc = 1'($urandom); id_Branch = 1'($urandom); id_ALUctr = CW'($urandom);
    id_busA = $urandom; id_busB = $urandom; id_imm32 = $urandom; id_pc = $urandom;
    flush = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    idle();
    m = '0;
    #2;
    push_expect();
    rst = 1;
    @(posedge clk); #1;
    step();
    step();
    rst = 0;

    // pass-through
    idle(); id_valid = 1; id_Ra = 1; id_Rb = 2; id_Rw = 3; id_RegWr = 1; id_busA = 32'h11;
    step();
    // load-use on Ra: lw $8 then add reading $8
    load_word(5'd8); step();
    alu_op(5'd8, 5'd9, 1'b1); step();
    step();
    idle(); step();
    // Rb ignored when unused, honoured when used
    load_word(5'd8); step();
    alu_op(5'd1, 5'd8, 1'b0); step();
    load_word(5'd8); step();
    alu_op(5'd1, 5'd8, 1'b1); step();
    step();
    // $0 destination never stalls
    load_word(5'd0); step();
    alu_op(5'd0, 5'd0, 1'b1); step();
    // flush wins over a hazard
    load_word(5'd8); step();
    alu_op(5'd8, 5'd2, 1'b1); flush = 1; step();
    idle(); step();
    // reset asserted in the middle of a stall cycle
    load_word(5'd8); step();
    alu_op(5'd8, 5'd2, 1'b1);
    push_expect();
    @(negedge clk); #2;
    m = '0;
    push_expect();
    rst = 1;
    @(posedge clk); #1;
    step();
    rst = 0;
    alu_op(5'd3, 5'd4, 1'b1); step();

    for (int i = 0; i < 400; i++) begin
      random_in();
      step();
    end
    idle();
    step();
    @(negedge clk); #3;
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
